// File: rtl/timer_ctrl_if.sv
// Signal bundle between the timer sequencing controller and its surroundings
// (user buttons, counter-chain strobes, status flags).
interface timer_ctrl_if;
  logic       start;
  logic       pause;
  logic       load_req;
  logic       zero;
  logic       cnt_load;
  logic       cnt_en;
  logic       cnt_clearn;
  logic       running;
  logic       paused;
  logic       done;
  logic [2:0] state;

  // master: buttons and counter chain side; slave: the controller
  modport master (
    output start, pause, load_req, zero,
    input  cnt_load, cnt_en, cnt_clearn, running, paused, done, state
  );

  modport slave (
    input  start, pause, load_req, zero,
    output cnt_load, cnt_en, cnt_clearn, running, paused, done, state
  );
endinterface

// File: rtl/timer_ctrl.sv
// Start/pause/resume/done sequencer for a cascaded mod-10 down-counter chain,
// with a prescaler issuing one decrement tick every TICK_DIV clocks in RUN.
module timer_ctrl #(
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned PW       = 16
) (
  input logic         clk,
  input logic         clear,
  timer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StReady = 3'd2,
    StRun   = 3'd3,
    StPause = 3'd4,
    StDone  = 3'd5
  } state_e;

  localparam logic [PW-1:0] PreMax = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick = (pre_q == PreMax);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.load_req) state_d = StLoad;
      end
      StLoad: begin
        state_d = StReady;
      end
      StReady: begin
        if (bus.load_req)   state_d = StLoad;
        else if (bus.start) state_d = bus.zero ? StDone : StRun;
      end
      StRun: begin
        if (bus.zero)       state_d = StDone;
        else if (bus.pause) state_d = StPause;
      end
      StPause: begin
        if (bus.load_req)   state_d = StLoad;
        else if (bus.start) state_d = StRun;
      end
      StDone: begin
        if (bus.load_req)   state_d = StLoad;
        else if (bus.start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // PAUSE keeps the partial tick so resume continues where it stopped
  always_comb begin
    pre_d = '0;
    if (state_q == StRun) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end else if (state_q == StPause) begin
      pre_d = pre_q;
    end
  end

  assign bus.cnt_clearn = (state_q != StIdle);
  assign bus.cnt_load   = (state_q != StLoad);
  assign bus.cnt_en     = (state_q == StRun) && tick && !bus.zero;
  assign bus.running    = (state_q == StRun);
  assign bus.paused     = (state_q == StPause);
  assign bus.done       = (state_q == StDone);
  assign bus.state      = state_q;

endmodule
